// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall controller interface: IF/ID, ID/EX and EX/MEM operand and
// control fields in, stall/flush controls out.
// With HAZARD_STALL_STATS_EN defined, the interface also carries the
// StallCycles/FlushCount statistics counters.
interface hazard_stall_unit_if
`ifdef HAZARD_STALL_STATS_EN
  #(parameter int STAT_W = 32)
`endif
  ;
  logic [4:0] IIRs;
  logic [4:0] IIRt;
  logic       UseRt;
  logic       beq;
  logic       bne;
  logic       jump;
  logic       BrTaken;
  logic [4:0] IERt;
  logic [4:0] IERd;
  logic       IEMemRead;
  logic       IERegWrite;
  logic [4:0] EMRd;
  logic       EMMemRead;
  logic       PCWrite;
  logic       IFIDWrite;
  logic       IDEXFlush;
  logic       IFIDFlush;
  logic       Stalling;
`ifdef HAZARD_STALL_STATS_EN
  logic [STAT_W-1:0] StallCycles;
  logic [STAT_W-1:0] FlushCount;

  modport master (
    output IIRs, IIRt, UseRt, beq, bne, jump, BrTaken,
           IERt, IERd, IEMemRead, IERegWrite, EMRd, EMMemRead,
    input  PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, Stalling,
           StallCycles, FlushCount
  );

  modport slave (
    input  IIRs, IIRt, UseRt, beq, bne, jump, BrTaken,
           IERt, IERd, IEMemRead, IERegWrite, EMRd, EMMemRead,
    output PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, Stalling,
           StallCycles, FlushCount
  );
`else
  modport master (
    output IIRs, IIRt, UseRt, beq, bne, jump, BrTaken,
           IERt, IERd, IEMemRead, IERegWrite, EMRd, EMMemRead,
    input  PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, Stalling
  );

  modport slave (
    input  IIRs, IIRt, UseRt, beq, bne, jump, BrTaken,
           IERt, IERd, IEMemRead, IERegWrite, EMRd, EMMemRead,
    output PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, Stalling
  );
`endif
endinterface

// File: rtl/hazard_stall_unit.sv
// Hazard detection and stall/flush controller for the 5-stage MIPS pipeline.
// Catches the RAW hazards that forwarding cannot cover (load-use and branch
// operands still in flight), freezes PC and IF/ID, injects ID/EX bubbles, and
// flushes IF/ID on a taken branch or a jump once no stall is pending.
// A small down-counter carries multi-cycle stalls, so a detection made while
// a stall is running is ignored rather than stacked.
// Optional macro HAZARD_STALL_STATS_EN adds saturating StallCycles and
// FlushCount statistics counters.
module hazard_stall_unit #(
  parameter int CNT_W = 2
`ifdef HAZARD_STALL_STATS_EN
  , parameter int STAT_W = 32
`endif
) (
  input logic              clk,
  input logic              reset,
  hazard_stall_unit_if.slave bus
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] need_s;
  logic             br_s;
  logic             luHaz_s;
  logic             baHaz_s;
  logic             bl1Haz_s;
  logic             bl2Haz_s;
  logic             stall_s;
  logic             flush_s;

  // Classify hazards; new detections only count while no stall is running.
  always_comb begin
    br_s     = bus.beq | bus.bne;
    luHaz_s  = bus.IEMemRead && (bus.IERt != 5'd0) &&
               ((bus.IERt == bus.IIRs) || (bus.UseRt && (bus.IERt == bus.IIRt)));
    baHaz_s  = br_s && bus.IERegWrite && !bus.IEMemRead && (bus.IERd != 5'd0) &&
               ((bus.IERd == bus.IIRs) || (bus.IERd == bus.IIRt));
    bl1Haz_s = br_s && bus.IEMemRead && (bus.IERt != 5'd0) &&
               ((bus.IERt == bus.IIRs) || (bus.IERt == bus.IIRt));
    bl2Haz_s = br_s && bus.EMMemRead && (bus.EMRd != 5'd0) &&
               ((bus.EMRd == bus.IIRs) || (bus.EMRd == bus.IIRt));
    need_s   = CNT_W'(0);
    if (cnt_r != CNT_W'(0)) begin
      need_s = CNT_W'(0);
    end else if (bl1Haz_s) begin
      need_s = CNT_W'(2);
    end else if (luHaz_s || baHaz_s || bl2Haz_s) begin
      need_s = CNT_W'(1);
    end else begin
      need_s = CNT_W'(0);
    end
  end

  // Stall and flush decisions; reset forces the pipeline to run freely.
  always_comb begin
    stall_s = 1'b0;
    flush_s = 1'b0;
    if (reset) begin
      stall_s = 1'b0;
      flush_s = 1'b0;
    end else begin
      stall_s = (cnt_r != CNT_W'(0)) || (need_s != CNT_W'(0));
      flush_s = !stall_s && (bus.jump || (br_s && bus.BrTaken));
    end
  end

  assign bus.PCWrite   = !stall_s;
  assign bus.IFIDWrite = !stall_s;
  assign bus.IDEXFlush = stall_s;
  assign bus.Stalling  = stall_s;
  assign bus.IFIDFlush = flush_s;

  // Stall down-counter: load need-1 on a fresh hazard, then count to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= CNT_W'(0);
    end else if (cnt_r != CNT_W'(0)) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else if (need_s != CNT_W'(0)) begin
      cnt_r <= need_s - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

`ifdef HAZARD_STALL_STATS_EN
  logic [STAT_W-1:0] stallCycles_r;
  logic [STAT_W-1:0] flushCount_r;

  // Saturating statistics: stall cycles and IF/ID flushes seen at each edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCycles_r <= {STAT_W{1'b0}};
      flushCount_r  <= {STAT_W{1'b0}};
    end else begin
      if (stall_s && (stallCycles_r != {STAT_W{1'b1}})) begin
        stallCycles_r <= stallCycles_r + STAT_W'(1);
      end else begin
        stallCycles_r <= stallCycles_r;
      end
      if (flush_s && (flushCount_r != {STAT_W{1'b1}})) begin
        flushCount_r <= flushCount_r + STAT_W'(1);
      end else begin
        flushCount_r <= flushCount_r;
      end
    end
  end

  assign bus.StallCycles = stallCycles_r;
  assign bus.FlushCount  = flushCount_r;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed testbench for hazard_stall_unit: hand-computed stall/flush
// expectations for load-use, branch-after-ALU/load, jump-during-stall and
// reset-mid-stall sequences, plus the statistics counters when
// HAZARD_STALL_STATS_EN is defined.
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checkCount = 0;
  int   errorCount = 0;

  hazard_stall_unit_if bus();

  hazard_stall_unit #(.CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Check every control output against the expected stall/flush state.
  task automatic checkOuts(input string tag, input logic expStall, input logic expFlush);
    checkValue({tag, "/PCWrite"},   32'(bus.PCWrite),   32'(!expStall));
    checkValue({tag, "/IFIDWrite"}, 32'(bus.IFIDWrite), 32'(!expStall));
    checkValue({tag, "/IDEXFlush"}, 32'(bus.IDEXFlush), 32'(expStall));
    checkValue({tag, "/Stalling"},  32'(bus.Stalling),  32'(expStall));
    checkValue({tag, "/IFIDFlush"}, 32'(bus.IFIDFlush), 32'(expFlush));
  endtask

  task automatic clearIn();
    bus.IIRs = 5'd0; bus.IIRt = 5'd0; bus.UseRt = 1'b0;
    bus.beq = 1'b0; bus.bne = 1'b0; bus.jump = 1'b0; bus.BrTaken = 1'b0;
    bus.IERt = 5'd0; bus.IERd = 5'd0; bus.IEMemRead = 1'b0; bus.IERegWrite = 1'b0;
    bus.EMRd = 5'd0; bus.EMMemRead = 1'b0;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // beq after a load still in EX: two stalls, then a taken branch flushes.
  task automatic runBl1();
    stepCycle(); clearIn();
    bus.beq = 1'b1; bus.IIRs = 5'd9; bus.IEMemRead = 1'b1; bus.IERt = 5'd9;
    #1 checkOuts("bl1_c1", 1'b1, 1'b0);
    stepCycle();
    #1 checkOuts("bl1_c2", 1'b1, 1'b0);
    stepCycle();
    bus.IEMemRead = 1'b0; bus.IERt = 5'd0; bus.BrTaken = 1'b1;
    #1 checkOuts("bl1_c3", 1'b0, 1'b1);
    stepCycle(); clearIn();
    #1 checkOuts("bl1_c4", 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clearIn();
    bus.IEMemRead = 1'b1; bus.IERt = 5'd8; bus.IIRs = 5'd8; bus.jump = 1'b1;
    #2 checkOuts("reset_forced", 1'b0, 1'b0);
    clearIn();
    @(negedge clk); reset = 1'b0;

    stepCycle();
    #1 checkOuts("idle", 1'b0, 1'b0);

    // Load-use on rs: one stall, then the bubble sits in ID/EX.
    stepCycle(); clearIn();
    bus.IEMemRead = 1'b1; bus.IERt = 5'd8; bus.IIRs = 5'd8;
    #1 checkOuts("lu_stall", 1'b1, 1'b0);
    stepCycle();
    bus.IEMemRead = 1'b0;
    #1 checkOuts("lu_after", 1'b0, 1'b0);

    // Load-use on rt only counts when the instruction reads rt.
    stepCycle(); clearIn();
    bus.IEMemRead = 1'b1; bus.IERt = 5'd8; bus.IIRt = 5'd8; bus.IIRs = 5'd3;
    #1 checkOuts("lu_rt_unused", 1'b0, 1'b0);
    bus.UseRt = 1'b1;
    #1 checkOuts("lu_rt_used", 1'b1, 1'b0);
    stepCycle(); clearIn();
    bus.IEMemRead = 1'b1; bus.IERt = 5'd0; bus.IIRs = 5'd0;
    #1 checkOuts("lu_reg0", 1'b0, 1'b0);

    runBl1();

    // Branch after ALU op: one stall; $0 destination never stalls.
    stepCycle(); clearIn();
    bus.bne = 1'b1; bus.UseRt = 1'b1; bus.IIRt = 5'd10; bus.IERegWrite = 1'b1; bus.IERd = 5'd10;
    #1 checkOuts("ba_stall", 1'b1, 1'b0);
    stepCycle();
    bus.IERegWrite = 1'b0; bus.IERd = 5'd0;
    #1 checkOuts("ba_after", 1'b0, 1'b0);
    stepCycle();
    bus.IERegWrite = 1'b1; bus.IERd = 5'd0; bus.IIRt = 5'd0;
    #1 checkOuts("ba_reg0", 1'b0, 1'b0);

    // ALU dependency for a non-branch is left to forwarding.
    stepCycle(); clearIn();
    bus.IERegWrite = 1'b1; bus.IERd = 5'd10; bus.IIRs = 5'd10;
    #1 checkOuts("alu_fwd", 1'b0, 1'b0);

    // Branch after a load already in MEM: one stall, then the taken flush.
    stepCycle(); clearIn();
    bus.beq = 1'b1; bus.IIRt = 5'd9; bus.EMMemRead = 1'b1; bus.EMRd = 5'd9;
    #1 checkOuts("bl2_stall", 1'b1, 1'b0);
    stepCycle();
    bus.EMMemRead = 1'b0; bus.BrTaken = 1'b1;
    #1 checkOuts("bl2_after", 1'b0, 1'b1);

    // Jump together with load-use: stall first, flush the next cycle.
    stepCycle(); clearIn();
    bus.jump = 1'b1; bus.IEMemRead = 1'b1; bus.IERt = 5'd8; bus.IIRs = 5'd8;
    #1 checkOuts("jump_stall", 1'b1, 1'b0);
    stepCycle();
    bus.IEMemRead = 1'b0;
    #1 checkOuts("jump_flush", 1'b0, 1'b1);

    // Reset in the first BL1 stall cycle abandons the stall.
    stepCycle(); clearIn();
    bus.beq = 1'b1; bus.IIRs = 5'd9; bus.IEMemRead = 1'b1; bus.IERt = 5'd9;
    #1 checkOuts("rst_mid_pre", 1'b1, 1'b0);
    #1 reset = 1'b1;
    #1 checkOuts("rst_mid_held", 1'b0, 1'b0);
    @(negedge clk); clearIn(); reset = 1'b0;
    stepCycle();
    #1 checkOuts("rst_mid_after", 1'b0, 1'b0);
`ifdef HAZARD_STALL_STATS_EN
    checkValue("stats_clr_stall", bus.StallCycles, 32'd0);
    checkValue("stats_clr_flush", bus.FlushCount, 32'd0);
`endif

    runBl1();
`ifdef HAZARD_STALL_STATS_EN
    checkValue("stats_stall", bus.StallCycles, 32'd2);
    checkValue("stats_flush", bus.FlushCount, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Hazard detection and stall/flush controller for the 5-stage pipelined MIPS CPU; the counterpart to the EX/ID bypassing logic.
- Detects RAW hazards that forwarding cannot resolve: load-use, and branch-in-ID operands not yet available.
- Freezes PC and IF/ID, inserts ID/EX bubbles for the required number of cycles, and flushes IF/ID on taken branch or jump.
- Stall cycles are counted in a registered down-counter, so multi-cycle stalls complete deterministically.

Parameters:
- CNT_W, 2, width of the stall down-counter (maximum stall length 2^CNT_W-1).
- STAT_W, 32, width of the stall statistics counter (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- IIRs  input  5  rs of instruction in IF/ID.
- IIRt  input  5  rt of instruction in IF/ID.
- UseRt  input  1  IF/ID instruction reads rt (R-type, beq, bne, sw).
- beq  input  1  IF/ID instruction is beq.
- bne  input  1  IF/ID instruction is bne.
- jump  input  1  IF/ID instruction is j/jal.
- BrTaken  input  1  ID-stage branch comparator result (valid only when beq|bne).
- IERt  input  5  rt of instruction in ID/EX.
- IERd  input  5  destination register of ID/EX (after RegDst mux).
- IEMemRead  input  1  ID/EX instruction is a load.
- IERegWrite  input  1  ID/EX instruction writes a register.
- EMRd  input  5  destination register in EX/MEM.
- EMMemRead  input  1  EX/MEM instruction is a load.
- PCWrite  output  1  1 = PC may update.
- IFIDWrite  output  1  1 = IF/ID may update.
- IDEXFlush  output  1  1 = load a bubble (all controls 0) into ID/EX.
- IFIDFlush  output  1  1 = clear IF/ID at the next edge.
- Stalling  output  1  1 = a stall is in progress this cycle.

Behaviour:
- Hazard detection is combinational and evaluated only when cnt==0. Let br = beq|bne.
  - LU (load-use): IEMemRead & IERt!=0 & (IERt==IIRs | (UseRt & IERt==IIRt)). Requires 1 stall.
  - BA (branch after ALU): br & IERegWrite & !IEMemRead & IERd!=0 & IERd∈{IIRs,IIRt}. Requires 1 stall.
  - BL1 (branch after load, load in EX): br & IEMemRead & IERt!=0 & IERt∈{IIRs,IIRt}. Requires 2 stalls; overrides LU.
  - BL2 (branch after load, load in MEM): br & EMMemRead & EMRd!=0 & EMRd∈{IIRs,IIRt}. Requires 1 stall.
- Let need = total stall cycles required (0, 1 or 2); when several hazards are present, the maximum applies.
- Stall this cycle: stall = (cnt!=0) | (need!=0).
- Counter update at the clock edge:
  - If cnt==0 and need!=0, cnt <= need-1.
  - Else if cnt!=0, cnt <= cnt-1.
  - While cnt!=0, new detections are ignored, so counts never stack.
- Outputs (combinational from cnt and the current inputs):
  - PCWrite = IFIDWrite = !stall.
  - IDEXFlush = stall.
  - Stalling = stall.
- IFIDFlush = !stall & (jump | (br & BrTaken)). A branch that is stalling never flushes; the flush is issued in the cycle the branch resolves.
- Latency:
  - The stall is asserted in the same cycle the hazard is seen.
  - A BL1 hazard yields exactly 2 consecutive stall cycles, then resolves with 0 further stall cycles (the load then sits in MEM/WB and forwarding covers it).
- Register $0 never causes a hazard.
- Reset (asynchronous, active-high): cnt <= 0 immediately. While reset is high, outputs are forced to PCWrite=1, IFIDWrite=1, IDEXFlush=0, IFIDFlush=0, Stalling=0 regardless of the other inputs. Reset asserted mid-stall abandons the stall; the first cycle after release is evaluated fresh.
- Simultaneous jump and hazard: the stall wins; the flush is deferred until stall=0.

Optional Feature:
- Macro: HAZARD_STALL_STATS_EN.
- Defined: adds output ports StallCycles [STAT_W-1:0] and FlushCount [STAT_W-1:0].
  - StallCycles increments on every clock edge where stall=1.
  - FlushCount increments on every clock edge where IFIDFlush=1.
  - Both clear on reset and saturate at all-ones.
- Not defined: neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
- Load-use: IEMemRead=1, IERt=8, IIRs=8, br=0 -> one cycle with PCWrite=0, IFIDWrite=0, IDEXFlush=1; next cycle (ID/EX holds the bubble) PCWrite=1.
- Branch after load: beq=1, IIRs=9, IEMemRead=1, IERt=9 -> exactly 2 stall cycles, counter 1 then 0; with BrTaken=1 in the third cycle -> IFIDFlush=1 for 1 cycle.
- Branch after ALU: bne=1, IIRt=10, IERegWrite=1, IERd=10, IEMemRead=0 -> exactly 1 stall cycle; IERd=0 with IIRt=0 -> no stall.
- Jump during stall: jump=1 together with an LU hazard -> IFIDFlush=0 in the stall cycle, IFIDFlush=1 in the following cycle.
- Reset mid-stall: assert reset during the first BL1 stall cycle -> outputs return to PCWrite=1, IDEXFlush=0 immediately; after release with no hazard, Stalling=0.
- With HAZARD_STALL_STATS_EN: run the BL1 case followed by one taken branch -> StallCycles=2, FlushCount=1.
